// File: rtl/chip8_draw_sequencer.sv
// chip8_draw_sequencer: DXYN sprite row fetch/draw sequencer with collision accumulation.
// Define DRAW_CLIP_EN to stop the sequence at the first row that falls below the screen.
module chip8_draw_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  vx,
  input  logic [7:0]  vy,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic [11:0] mem_addr,
  output logic        mem_read,
  input  logic [7:0]  mem_data,
  output logic        draw,
  output logic [5:0]  draw_x,
  output logic [4:0]  draw_y,
  output logic [3:0]  draw_row_index,
  output logic [7:0]  sprite_data,
  input  logic        collision,
  output logic        busy,
  output logic        done,
  output logic        vf_out
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, FINISH} state_t;
  state_t state;
  logic [3:0] n_q, row, row_nx;
  logic [11:0] base;
  logic acc, clip, unused_hi;
  assign row_nx = row + 4'd1;
  assign unused_hi = ^{vx[7:6], vy[7:5]};
`ifdef DRAW_CLIP_EN
  assign clip = ({1'b0, draw_y} + {2'b00, row_nx}) >= 6'd32;
`else
  assign clip = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      {n_q, row, base, acc} <= '0;
      {mem_addr, mem_read, draw, draw_x, draw_y, draw_row_index} <= '0;
      {sprite_data, busy, done, vf_out} <= '0;
    end else begin
      done <= 1'b0;
      draw <= 1'b0;
      mem_read <= 1'b0;
      case (state)
        IDLE: if (start) begin
          draw_x <= vx[5:0];
          draw_y <= vy[4:0];
          n_q <= n;
          base <= i_addr;
          row <= '0;
          acc <= 1'b0;
          vf_out <= 1'b0;
          busy <= 1'b1;
          if (n == 4'd0) begin
            state <= FINISH;
            done <= 1'b1;
          end else begin
            state <= FETCH;
            mem_read <= 1'b1;
            mem_addr <= i_addr;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          sprite_data <= mem_data;
          draw <= 1'b1;
          draw_row_index <= row;
          state <= DRAW;
        end
        DRAW: begin
          acc <= acc | collision;
          if (row_nx < n_q && !clip) begin
            row <= row_nx;
            mem_read <= 1'b1;
            mem_addr <= base + {8'd0, row_nx};
            state <= FETCH;
          end else begin
            done <= 1'b1;
            vf_out <= acc | collision;
            state <= FINISH;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chip8_draw_sequencer.sv
// tb_chip8_draw_sequencer: directed checks of the DXYN draw sequencer against hand-computed values.
module tb_chip8_draw_sequencer;
  logic clk = 0, reset = 1, start = 0, collision, busy, done, vf_out, mem_read, draw;
  logic [7:0] vx = 0, vy = 0, mem_data = 0, sprite_data;
  logic [3:0] n = 0, draw_row_index;
  logic [11:0] i_addr = 0, mem_addr;
  logic [5:0] draw_x;
  logic [4:0] draw_y;
  logic [7:0] mem [0:4095];
  logic [15:0] coll_mask = 0;
  logic [11:0] addr_log [16];
  logic [3:0] row_log [16];
  logic [7:0] data_log [16];
  int n_addr, n_draw, done_cyc, checks = 0, fails = 0;
  logic vf_at_done, vf_c1, stable;

  chip8_draw_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .vx(vx), .vy(vy), .n(n), .i_addr(i_addr),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_data(mem_data), .draw(draw),
    .draw_x(draw_x), .draw_y(draw_y), .draw_row_index(draw_row_index),
    .sprite_data(sprite_data), .collision(collision), .busy(busy), .done(done), .vf_out(vf_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_read) mem_data <= mem[mem_addr];
  assign collision = draw && coll_mask[draw_row_index];

  task automatic run_seq(input logic [7:0] x, input logic [7:0] y, input logic [3:0] nn, input logic [11:0] ia);
    @(negedge clk);
    vx = x; vy = y; n = nn; i_addr = ia; start = 1;
    @(negedge clk);
    start = 0;
    n_addr = 0; n_draw = 0; done_cyc = 0; stable = 1; vf_c1 = vf_out; vf_at_done = 0;
    for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
      if (c > 1) @(negedge clk);
      if (mem_read && n_addr < 16) begin addr_log[n_addr] = mem_addr; n_addr++; end
      if (draw && n_draw < 16) begin row_log[n_draw] = draw_row_index; data_log[n_draw] = sprite_data; n_draw++; end
      if (draw_x !== x[5:0] || draw_y !== y[4:0]) stable = 0;
      if (done) begin done_cyc = c; vf_at_done = vf_out; end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, draw, mem_read, vf_out, mem_addr, draw_x, draw_y, draw_row_index, sprite_data} !== '0) begin
      fails++; $display("FAIL reset_outputs: got busy=%b done=%b draw=%b rd=%b vf=%b addr=%h x=%h y=%h row=%h data=%h, required all 0",
        busy, done, draw, mem_read, vf_out, mem_addr, draw_x, draw_y, draw_row_index, sprite_data);
    end
  endtask

  task automatic test_font;
    logic [7:0] font [5] = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
    for (int k = 0; k < 5; k++) mem[12'h050 + k] = font[k];
    coll_mask = 0;
    run_seq(8'h05, 8'h03, 4'd5, 12'h050);
    checks++; if (n_addr != 5) begin fails++; $display("FAIL font_reads: got %0d required 5", n_addr); end
    checks++; if (n_draw != 5) begin fails++; $display("FAIL font_draws: got %0d required 5", n_draw); end
    for (int k = 0; k < 5 && k < n_addr && k < n_draw; k++) begin
      checks++; if (addr_log[k] !== 12'h050 + k) begin fails++; $display("FAIL font_addr%0d: got %h required %h", k, addr_log[k], 12'h050 + k); end
      checks++; if (row_log[k] !== k[3:0]) begin fails++; $display("FAIL font_row%0d: got %0d required %0d", k, row_log[k], k); end
      checks++; if (data_log[k] !== font[k]) begin fails++; $display("FAIL font_data%0d: got %h required %h", k, data_log[k], font[k]); end
    end
    checks++; if (done_cyc != 16) begin fails++; $display("FAIL font_done_cycle: got %0d required 16", done_cyc); end
    checks++; if (vf_at_done !== 1'b0) begin fails++; $display("FAIL font_vf: got %b required 0", vf_at_done); end
    checks++; if (!stable) begin fails++; $display("FAIL font_xy_stable: draw_x/draw_y changed mid-sequence, required %h/%h", 6'h05, 5'h03); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL font_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_n0;
    run_seq(8'h01, 8'h02, 4'd0, 12'h300);
    checks++; if (done_cyc != 1) begin fails++; $display("FAIL n0_done_cycle: got %0d required 1", done_cyc); end
    checks++; if (n_addr != 0 || n_draw != 0) begin fails++; $display("FAIL n0_activity: got reads=%0d draws=%0d required 0/0", n_addr, n_draw); end
  endtask

  task automatic test_wrap_xy;
    mem[12'h100] = 8'hAA;
    run_seq(8'h45, 8'h25, 4'd1, 12'h100);
    checks++; if (draw_x !== 6'd5 || draw_y !== 5'd5) begin fails++; $display("FAIL wrap_xy: got x=%0d y=%0d required 5/5", draw_x, draw_y); end
    checks++; if (done_cyc != 4) begin fails++; $display("FAIL wrap_xy_done_cycle: got %0d required 4", done_cyc); end
  endtask

  task automatic test_addr_wrap;
    logic [11:0] exp_a [3] = '{12'hFFE, 12'hFFF, 12'h000};
    logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 3; k++) mem[exp_a[k]] = exp_d[k];
    run_seq(8'h00, 8'h00, 4'd3, 12'hFFE);
    checks++; if (n_addr != 3) begin fails++; $display("FAIL wrap_reads: got %0d required 3", n_addr); end
    for (int k = 0; k < 3 && k < n_addr && k < n_draw; k++) begin
      checks++; if (addr_log[k] !== exp_a[k]) begin fails++; $display("FAIL wrap_addr%0d: got %h required %h", k, addr_log[k], exp_a[k]); end
      checks++; if (data_log[k] !== exp_d[k]) begin fails++; $display("FAIL wrap_data%0d: got %h required %h", k, data_log[k], exp_d[k]); end
    end
  endtask

  task automatic test_collision;
    coll_mask = 16'h0002;
    run_seq(8'h10, 8'h08, 4'd4, 12'h050);
    checks++; if (done_cyc != 13) begin fails++; $display("FAIL coll_done_cycle: got %0d required 13", done_cyc); end
    checks++; if (vf_at_done !== 1'b1) begin fails++; $display("FAIL coll_vf: got %b required 1", vf_at_done); end
    coll_mask = 0;
    repeat (3) @(negedge clk);
    checks++; if (vf_out !== 1'b1) begin fails++; $display("FAIL coll_vf_hold: got %b required 1", vf_out); end
    run_seq(8'h10, 8'h08, 4'd1, 12'h050);
    checks++; if (vf_c1 !== 1'b0) begin fails++; $display("FAIL coll_vf_cleared: got %b required 0", vf_c1); end
    checks++; if (vf_at_done !== 1'b0) begin fails++; $display("FAIL coll_vf_second: got %b required 0", vf_at_done); end
  endtask

  task automatic test_reset_mid;
    int bad;
    @(negedge clk);
    vx = 8'h07; vy = 8'h01; n = 4'd4; i_addr = 12'h050; start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    checks++; if ({busy, mem_read, draw} !== 3'b100) begin fails++; $display("FAIL mid_in_wait: got busy/rd/draw=%b required 100", {busy, mem_read, draw}); end
    reset = 1;
    #1;
    checks++;
    if ({busy, done, draw, mem_read, vf_out, mem_addr, draw_x, draw_y, draw_row_index, sprite_data} !== '0) begin
      fails++; $display("FAIL mid_reset_outputs: got busy=%b done=%b draw=%b rd=%b vf=%b addr=%h x=%h y=%h row=%h data=%h, required all 0",
        busy, done, draw, mem_read, vf_out, mem_addr, draw_x, draw_y, draw_row_index, sprite_data);
    end
    @(negedge clk);
    reset = 0;
    bad = 0;
    repeat (20) begin @(negedge clk); if (draw || done || busy) bad++; end
    checks++; if (bad != 0) begin fails++; $display("FAIL mid_no_resume: got %0d active cycles required 0", bad); end
    run_seq(8'h07, 8'h01, 4'd2, 12'h050);
    checks++; if (done_cyc != 7 || n_draw != 2) begin fails++; $display("FAIL mid_restart: got done=%0d draws=%0d required 7/2", done_cyc, n_draw); end
  endtask

  task automatic test_clip;
    run_seq(8'h00, 8'd30, 4'd5, 12'h050);
`ifdef DRAW_CLIP_EN
    checks++; if (n_draw != 2 || n_addr != 2) begin fails++; $display("FAIL clip_draws: got draws=%0d reads=%0d required 2/2", n_draw, n_addr); end
    checks++; if (done_cyc != 7) begin fails++; $display("FAIL clip_done_cycle: got %0d required 7", done_cyc); end
`else
    checks++; if (n_draw != 5 || n_addr != 5) begin fails++; $display("FAIL noclip_draws: got draws=%0d reads=%0d required 5/5", n_draw, n_addr); end
    checks++; if (done_cyc != 16) begin fails++; $display("FAIL noclip_done_cycle: got %0d required 16", done_cyc); end
`endif
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    test_reset;
    @(negedge clk);
    reset = 0;
    test_font;
    test_n0;
    test_wrap_xy;
    test_addr_wrap;
    test_collision;
    test_reset_mid;
    test_clip;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
